// File: rtl/cefb_pkg.sv
// Shared types and widths for the DDR3 stream writer and its FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cefb_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 26;
    localparam int AVL_SIZE_W = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/cefb_sync_fifo.sv
// Single-clock show-ahead FIFO with level output and a one-ahead peek of the next entry.
// Latency: a push at edge N is visible on head after edge N.
// Backpressure: pushes while full and pops while empty are ignored; full/empty are decodes of the registered level.
module cefb_sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_dat,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DATA_W-1:0]        head,
    output logic [DATA_W-1:0]        head_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push, do_pop;

    // Qualify requests against the registered flags and compute next pointers/level
    always_comb begin
        do_push    = push && !full;
        do_pop     = pop && !empty;
        rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
        wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop ? rd_ptr_nxt : rd_ptr_q;
        level_d    = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    // Pointer and level registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head      = mem_q[rd_ptr_q];
    assign head_next = mem_q[rd_ptr_nxt];

endmodule

// File: rtl/ddr3_stream_writer.sv
// Buffers a valid/ready beat stream and drains it as Avalon-MM write bursts into a circular DDR3 address window.
// Latency: a beat pushed at edge N is driven on avl_wdata after edge N+1, so the controller samples it at N+2 at the earliest.
// Backpressure: in_ready falls only when the FIFO is full; avl_ready low holds the current beat, address and size.
module ddr3_stream_writer
    import cefb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  flush_done,
    input  logic                  restart,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [ADDR_W-1:0]     cfg_span,
    input  logic                  avl_ready,
    output logic                  avl_write_req,
    output logic                  avl_burstbegin,
    output logic [ADDR_W-1:0]     avl_addr,
    output logic [AVL_SIZE_W-1:0] avl_size,
    output logic [DATA_W-1:0]     avl_wdata,
    output logic [DATA_W/8-1:0]   avl_be,
    output logic [31:0]           beats_written
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int EXT_W = ADDR_W + 1;

    logic                  fifo_full, fifo_empty, push, pop;
    logic [LVL_W-1:0]      fifo_level;
    logic [DATA_W-1:0]     fifo_head, fifo_head_next;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     wptr_q, wptr_d, wptr_eff;
    logic [ADDR_W-1:0]     avl_addr_q, avl_addr_d;
    logic [AVL_SIZE_W-1:0] avl_size_q, avl_size_d;
    logic [AVL_SIZE_W-1:0] beat_cnt_q, beat_cnt_d, burst_len;
    logic [DATA_W-1:0]     avl_wdata_q, avl_wdata_d;
    logic                  avl_write_req_q, avl_write_req_d;
    logic                  avl_burstbegin_q, avl_burstbegin_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  flush_done_q, flush_done_d;
    logic [31:0]           beats_written_q, beats_written_d;
    logic [EXT_W-1:0]      win_end, room, len_ext, wptr_adv;

    cefb_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (srst),
        .push      (push),
        .push_dat  (in_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .head      (fifo_head),
        .head_next (fifo_head_next)
    );

    // Handshakes and window arithmetic, one bit wider so base+span cannot overflow
    always_comb begin
        push      = in_valid && !fifo_full;
        pop       = avl_write_req_q && avl_ready;
        wptr_eff  = (state_q == IDLE && restart) ? cfg_base : wptr_q;
        win_end   = {1'b0, cfg_base} + {1'b0, cfg_span};
        room      = win_end - {1'b0, wptr_eff};
        wptr_adv  = {1'b0, wptr_q} + EXT_W'(avl_size_q);
        len_ext   = EXT_W'(fifo_level);
        if (len_ext > EXT_W'(BURST_LEN)) begin
            len_ext = EXT_W'(BURST_LEN);
        end
        if (len_ext > room) begin
            len_ext = room;
        end
        burst_len = AVL_SIZE_W'(len_ext);
    end

    // Burst FSM next-state: launch, beat accounting, pointer wrap and flush completion
    always_comb begin
        state_d          = state_q;
        wptr_d           = wptr_eff;
        avl_addr_d       = avl_addr_q;
        avl_size_d       = avl_size_q;
        beat_cnt_d       = beat_cnt_q;
        avl_wdata_d      = avl_wdata_q;
        avl_write_req_d  = avl_write_req_q;
        avl_burstbegin_d = 1'b0;
        flush_pend_d     = flush_pend_q || flush;
        flush_done_d     = 1'b0;
        beats_written_d  = beats_written_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && (fifo_level >= LVL_W'(BURST_LEN) || flush_pend_q)) begin
                    state_d          = BURST;
                    avl_write_req_d  = 1'b1;
                    avl_burstbegin_d = 1'b1;
                    avl_addr_d       = wptr_eff;
                    avl_size_d       = burst_len;
                    beat_cnt_d       = '0;
                    avl_wdata_d      = fifo_head;
                end else if (flush_pend_q && fifo_empty && !push) begin
                    flush_pend_d = 1'b0;
                    flush_done_d = 1'b1;
                end
            end
            BURST: begin
                if (pop) begin
                    beats_written_d = beats_written_q + 32'd1;
                    beat_cnt_d      = beat_cnt_q + AVL_SIZE_W'(1);
                    avl_wdata_d     = fifo_head_next;
                    if (beat_cnt_q == avl_size_q - AVL_SIZE_W'(1)) begin
                        state_d         = IDLE;
                        avl_write_req_d = 1'b0;
                        wptr_d          = (wptr_adv == win_end) ? cfg_base : ADDR_W'(wptr_adv);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state and registered outputs; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q          <= IDLE;
            wptr_q           <= cfg_base;
            avl_addr_q       <= cfg_base;
            avl_size_q       <= '0;
            beat_cnt_q       <= '0;
            avl_wdata_q      <= '0;
            avl_write_req_q  <= 1'b0;
            avl_burstbegin_q <= 1'b0;
            flush_pend_q     <= 1'b0;
            flush_done_q     <= 1'b0;
            beats_written_q  <= '0;
        end else begin
            state_q          <= state_d;
            wptr_q           <= wptr_d;
            avl_addr_q       <= avl_addr_d;
            avl_size_q       <= avl_size_d;
            beat_cnt_q       <= beat_cnt_d;
            avl_wdata_q      <= avl_wdata_d;
            avl_write_req_q  <= avl_write_req_d;
            avl_burstbegin_q <= avl_burstbegin_d;
            flush_pend_q     <= flush_pend_d;
            flush_done_q     <= flush_done_d;
            beats_written_q  <= beats_written_d;
        end
    end

    assign in_ready       = !fifo_full;
    assign flush_done     = flush_done_q;
    assign avl_write_req  = avl_write_req_q;
    assign avl_burstbegin = avl_burstbegin_q;
    assign avl_addr       = avl_addr_q;
    assign avl_size       = avl_size_q;
    assign avl_wdata      = avl_wdata_q;
    assign avl_be         = '1;
    assign beats_written  = beats_written_q;

endmodule
